// File: rtl/vote_collector_if.sv
// Key inputs and ballot outputs of the vote collector, grouped for the voter front end.
interface vote_collector_if;
   logic [3:0] key_n;
   logic       ctl_n;
   logic       a;
   logic       b;
   logic       c;
   logic       d;
   logic       votes_valid;
   logic [1:0] state;
   logic       press;

   modport master (
      output key_n, ctl_n,
      input  a, b, c, d, votes_valid, state, press
   );

   modport slave (
      input  key_n, ctl_n,
      output a, b, c, d, votes_valid, state, press
   );
endinterface

// File: rtl/vote_collector.sv
// Debounces four vote keys plus a control key and runs an IDLE/COLLECT/LOCKED ballot.
// A key press acts DEB_CYCLES+3 edges after the raw fall; no backpressure, keys are free-running.
module vote_collector #(
   parameter int DEB_CYCLES     = 240000,
   parameter int CNT_W          = 18,
   parameter int TIMEOUT_CYCLES = 0,
   parameter int TO_W           = 32
) (
   input  logic            clk,
   input  logic            rst,
   vote_collector_if.slave vif
);
   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_COLLECT = 2'b01,
      S_LOCKED  = 2'b10
   } state_t;

   localparam int               NK      = 5;
   localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES);
   localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);

   // bit 0 is the control key, bits 4:1 are vote keys 3:0 (a..d)
   logic [NK-1:0]    raw;
   logic [NK-1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
   logic [NK-1:0]    arm_q, arm_d, deb_q, deb_d, evt_q, evt_d;
   logic [CNT_W-1:0] cnt_q [NK];
   logic [CNT_W-1:0] cnt_d [NK];
   logic [CNT_W-1:0] cnt_inc;

   state_t           state_q, state_d;
   logic [3:0]       votes_q, votes_d;
   logic             valid_q, valid_d;
   logic             press_q, press_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic [3:0]       vote_evt;
   logic             ctl_evt;
   logic             any_evt;

   assign raw = {vif.key_n, vif.ctl_n};

   // Synchronizers reset to "pressed" and a key is only armed once it has been seen released,
   // so a key held through reset never yields an event.
   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      arm_d   = arm_q | sync2_q;
      deb_d   = deb_q;
      evt_d   = '0;
      cnt_inc = '0;
      for (int i = 0; i < NK; i++) begin
         cnt_d[i] = '0;
         if (arm_q[i] && (sync2_q[i] != deb_q[i])) begin
            cnt_inc = cnt_q[i] + CNT_W'(1);
            if (cnt_inc == DEB_MAX) begin
               deb_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_inc;
            end
         end
         evt_d[i] = deb_q[i] & ~deb_d[i];
      end
   end

   assign vote_evt = evt_q[4:1];
   assign ctl_evt  = evt_q[0];
   assign any_evt  = |evt_q;

   always_comb begin
      state_d = state_q;
      votes_d = votes_q;
      to_d    = to_q;
      press_d = any_evt;
      case (state_q)
         S_IDLE: begin
            if (ctl_evt) begin
               state_d = S_COLLECT;
               to_d    = '0;
            end
         end
         S_COLLECT: begin
            votes_d = votes_q ^ vote_evt;
            if (any_evt) begin
               to_d = '0;
            end else if (to_q != '1) begin
               to_d = to_q + TO_W'(1);
            end
            if (ctl_evt) begin
               state_d = S_LOCKED;
            end else if ((TIMEOUT_CYCLES != 0) && !any_evt && (to_d == TO_MAX)) begin
               state_d = S_LOCKED;
            end
         end
         S_LOCKED: begin
            if (ctl_evt) begin
               state_d = S_IDLE;
               votes_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            votes_d = '0;
         end
      endcase
      valid_d = (state_d == S_LOCKED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         arm_q   <= '0;
         deb_q   <= '1;
         evt_q   <= '0;
         for (int i = 0; i < NK; i++) begin
            cnt_q[i] <= '0;
         end
         state_q <= S_IDLE;
         votes_q <= '0;
         valid_q <= 1'b0;
         press_q <= 1'b0;
         to_q    <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         arm_q   <= arm_d;
         deb_q   <= deb_d;
         evt_q   <= evt_d;
         for (int i = 0; i < NK; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         state_q <= state_d;
         votes_q <= votes_d;
         valid_q <= valid_d;
         press_q <= press_d;
         to_q    <= to_d;
      end
   end

   assign vif.a           = votes_q[3];
   assign vif.b           = votes_q[2];
   assign vif.c           = votes_q[1];
   assign vif.d           = votes_q[0];
   assign vif.state       = state_q;
   assign vif.votes_valid = valid_q;
   assign vif.press       = press_q;
endmodule
